// File: rtl/acc_n.sv
// acc_n: block accumulator downstream of the n-bit adder.
// Sums DEPTH consecutive {over, sum} results into an ACC_W-bit total, presents it
// on a valid/ready handshake and flags accumulator overflow with a sticky bit.
// Build option: define ACC_SAT_EN to clamp the accumulator at all-ones on overflow
// instead of wrapping modulo 2^ACC_W.
module acc_n #(
  parameter int unsigned n     = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ACC_W = 12
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [n-1:0]               sum_i,
  input  logic                       over_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic                       clr_i,
  output logic [ACC_W-1:0]           acc_o,
  output logic [$clog2(DEPTH+1)-1:0] cnt_o,
  output logic                       ovf_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(DEPTH - 1);

  typedef enum logic {StAcc, StHold} state_e;

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CntW-1:0]  cnt_q;
  logic             ovf_q;

  logic [ACC_W-1:0] operand;
  logic [ACC_W:0]   sum_full;
  logic             carry;
  logic [ACC_W-1:0] acc_next;

  // Zero-extend {over, sum}; the carry-out is the operand's top bit.
  always_comb begin
    operand       = '0;
    operand[n:0]  = {over_i, sum_i};
  end

  // One extra bit catches the carry out of the accumulator MSB.
  always_comb begin
    sum_full = {1'b0, acc_q} + {1'b0, operand};
    carry    = sum_full[ACC_W];
`ifdef ACC_SAT_EN
    acc_next = carry ? '1 : sum_full[ACC_W-1:0];
`else
    acc_next = sum_full[ACC_W-1:0];
`endif
  end

  // Block FSM with accumulator, count and sticky overflow state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StAcc;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (clr_i) begin
      // Clear beats both accept and handshake; any offered input is dropped.
      state_q <= StAcc;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StAcc: begin
          if (in_valid_i) begin
            acc_q <= acc_next;
            cnt_q <= cnt_q + CntW'(1);
            if (carry) begin
              ovf_q <= 1'b1;
            end
            if (cnt_q == LastCnt) begin
              state_q <= StHold;
            end
          end
        end
        StHold: begin
          if (out_ready_i) begin
            state_q <= StAcc;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
          end
        end
        default: state_q <= StAcc;
      endcase
    end
  end

  // Handshake signals decode the state only; no path from out_ready_i.
  always_comb begin
    in_ready_o  = (state_q == StAcc);
    out_valid_o = (state_q == StHold);
  end

  assign acc_o = acc_q;
  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: tb/tb_acc_n.sv
// Self-checking bench for acc_n: two instances (ACC_W=12 and ACC_W=10) share stimulus.
// A behavioural model tracks running state; block totals go through a scoreboard queue.
module tb_acc_n;

  localparam int unsigned N     = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  logic           clk;
  logic           rst;
  logic [N-1:0]   sum;
  logic           over;
  logic           in_valid;
  logic           clr;
  logic           out_ready;

  logic           in_ready_a, out_valid_a, ovf_a;
  logic [11:0]    acc_a;
  logic [CntW-1:0] cnt_a;
  logic           in_ready_b, out_valid_b, ovf_b;
  logic [9:0]     acc_b;
  logic [CntW-1:0] cnt_b;

  acc_n #(.n(N), .DEPTH(DEPTH), .ACC_W(12)) u_dut_a (
    .clk_i       (clk),
    .rst_i       (rst),
    .sum_i       (sum),
    .over_i      (over),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready_a),
    .clr_i       (clr),
    .acc_o       (acc_a),
    .cnt_o       (cnt_a),
    .ovf_o       (ovf_a),
    .out_valid_o (out_valid_a),
    .out_ready_i (out_ready)
  );

  acc_n #(.n(N), .DEPTH(DEPTH), .ACC_W(10)) u_dut_b (
    .clk_i       (clk),
    .rst_i       (rst),
    .sum_i       (sum),
    .over_i      (over),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready_b),
    .clr_i       (clr),
    .acc_o       (acc_b),
    .cnt_o       (cnt_b),
    .ovf_o       (ovf_b),
    .out_valid_o (out_valid_b),
    .out_ready_i (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  int m_acc_a, m_acc_b, m_cnt;
  bit m_ovf_a, m_ovf_b, m_hold;

  typedef struct { int tot_a; int tot_b; } total_t;
  total_t sb_q[$];

  function automatic void model_add(input int w, input int a, input int op,
                                    output int r, output bit c);
    int s;
    s = a + op;
    c = (s >= (1 << w));
`ifdef ACC_SAT_EN
    r = c ? ((1 << w) - 1) : s;
`else
    r = s % (1 << w);
`endif
  endfunction

  task automatic model_clear();
    m_acc_a = 0; m_acc_b = 0; m_cnt = 0;
    m_ovf_a = 0; m_ovf_b = 0; m_hold = 0;
  endtask

  // One clock: pre-edge handshake checks and model update, post-edge state checks.
  task automatic step();
    int op, r;
    bit c;
    total_t t;
    check_eq("in_ready_a", in_ready_a, !m_hold);
    check_eq("out_valid_a", out_valid_a, m_hold);
    check_eq("out_valid_b", out_valid_b, m_hold);
    op = {over, sum};
    if (clr) begin
      if (m_hold && sb_q.size() > 0) void'(sb_q.pop_front());
      model_clear();
    end else if (m_hold) begin
      if (out_ready) begin
        check_eq("sb_nonempty", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          t = sb_q.pop_front();
          check_eq("total_a", acc_a, t.tot_a);
          check_eq("total_b", acc_b, t.tot_b);
        end
        model_clear();
      end
    end else if (in_valid) begin
      model_add(12, m_acc_a, op, r, c);
      m_acc_a = r; if (c) m_ovf_a = 1;
      model_add(10, m_acc_b, op, r, c);
      m_acc_b = r; if (c) m_ovf_b = 1;
      m_cnt++;
      if (m_cnt == DEPTH) begin
        m_hold = 1;
        t.tot_a = m_acc_a;
        t.tot_b = m_acc_b;
        sb_q.push_back(t);
      end
    end
    @(posedge clk);
    #1;
    check_eq("acc_a", acc_a, m_acc_a);
    check_eq("acc_b", acc_b, m_acc_b);
    check_eq("cnt_a", cnt_a, m_cnt);
    check_eq("cnt_b", cnt_b, m_cnt);
    check_eq("ovf_a", ovf_a, m_ovf_a);
    check_eq("ovf_b", ovf_b, m_ovf_b);
  endtask

  task automatic drv(input bit v, input int val, input bit ordy = 0, input bit c = 0);
    in_valid  = v;
    {over, sum} = 9'(val);
    out_ready = ordy;
    clr       = c;
    step();
  endtask

  initial begin
    rst = 1'b1; sum = '0; over = 1'b0; in_valid = 1'b0; clr = 1'b0; out_ready = 1'b0;
    model_clear();
    #2;
    check_eq("rst_acc", acc_a, 0);
    check_eq("rst_cnt", cnt_a, 0);
    check_eq("rst_valid", out_valid_a, 0);
    check_eq("rst_ready", in_ready_a, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset mid-block discards the partial sum asynchronously.
    drv(1, 10);
    drv(1, 20);
    check_eq("pre_rst_acc", acc_a, 30);
    rst = 1'b1;
    #2;
    check_eq("arst_acc", acc_a, 0);
    check_eq("arst_cnt", cnt_a, 0);
    check_eq("arst_ovf", ovf_a, 0);
    check_eq("arst_valid", out_valid_a, 0);
    rst = 1'b0;
    model_clear();
    #1;
    check_eq("arst_ready", in_ready_a, 1);

    // Basic block with held output and ignored input.
    drv(1, 10); drv(1, 20); drv(1, 30); drv(1, 40);
    check_eq("basic_valid", out_valid_a, 1);
    check_eq("basic_acc", acc_a, 100);
    check_eq("basic_cnt", cnt_a, DEPTH);
    for (int i = 0; i < 3; i++) drv(1, 99);
    check_eq("held_acc", acc_a, 100);
    drv(1, 99, 1);
    check_eq("hs_acc", acc_a, 0);
    check_eq("hs_cnt", cnt_a, 0);

    // Carry bit as operand MSB; ACC_W=10 instance overflows.
    for (int i = 0; i < 4; i++) drv(1, 511);
    check_eq("carry_acc", acc_a, 2044);
    check_eq("carry_ovf", ovf_a, 0);
`ifdef ACC_SAT_EN
    check_eq("ovf10_acc", acc_b, 1023);
`else
    check_eq("ovf10_acc", acc_b, 1020);
`endif
    check_eq("ovf10_flag", ovf_b, 1);
    drv(0, 0, 1);
    check_eq("ovf_cleared", ovf_b, 0);

    // Clear collides with an offered input.
    drv(1, 5); drv(1, 6);
    drv(1, 7, 0, 1);
    check_eq("clr_acc", acc_a, 0);
    check_eq("clr_cnt", cnt_a, 0);
    for (int i = 0; i < 4; i++) drv(1, 1);
    check_eq("after_clr_acc", acc_a, 4);
    // Next block's first input lands right after the handshake.
    drv(1, 1, 1);
    drv(1, 3);
    check_eq("b2b_acc", acc_a, 3);
    drv(0, 0, 0, 1);

    // Bubbles between inputs, then clear while holding.
    drv(1, 1); drv(0, 0); drv(1, 2); drv(0, 0); drv(0, 0);
    check_eq("bubble_cnt", cnt_a, 2);
    drv(1, 3); drv(0, 0); drv(1, 4);
    check_eq("bubble_acc", acc_a, 10);
    drv(0, 0, 0, 1);
    check_eq("clr_hold_valid", out_valid_a, 0);
    check_eq("clr_hold_acc", acc_a, 0);
    drv(0, 0);

    check_eq("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_n.md
# acc_n

Accumulation stage that sits directly downstream of the n-bit adder. It consumes each `{over, sum}` result, extends it to a wider accumulator, and sums `DEPTH` consecutive results into one block total. The total is presented on a valid/ready output handshake. Overflow of the accumulator is reported with a sticky flag. Optionally, the accumulator saturates instead of wrapping.

## Interface
- `n`, 8: width of the adder sum being consumed.
- `DEPTH`, 4: number of results summed per block; must be ≥ 2.
- `ACC_W`, 12: accumulator width; must be ≥ n+1.
- `clk_i`  in  1  single clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `sum_i`  in  n  adder sum.
- `over_i`  in  1  adder carry-out; treated as bit n of the operand.
- `in_valid_i`  in  1  `sum_i`/`over_i` valid this cycle.
- `in_ready_o`  out  1  stage accepts a result this cycle.
- `clr_i`  in  1  synchronous abort/clear.
- `acc_o`  out  ACC_W  accumulator register (running, then final total).
- `cnt_o`  out  $clog2(DEPTH+1)  results accepted in the current block.
- `ovf_o`  out  1  sticky overflow for the current block.
- `out_valid_o`  out  1  `acc_o` holds a completed block total.
- `out_ready_i`  in  1  consumer accepts the total.

## Operation
- Operand: `{over_i, sum_i}` is zero-extended to `ACC_W`, giving a range of 0 .. 2^(n+1)-1.
- The FSM has two states, ACC and HOLD. Reset state is ACC.
- **ACC state**
  - `in_ready_o`=1 and `out_valid_o`=0.
  - Accept condition: `in_valid_i` && `in_ready_o`. On accept: `acc` += operand and `cnt` += 1.
  - If the accepted result makes `cnt` equal `DEPTH`, the FSM moves to HOLD on that edge.
  - A cycle with no `in_valid_i` changes nothing.
- **HOLD state**
  - `in_ready_o`=0 and `out_valid_o`=1.
  - `acc_o`, `cnt_o` (= `DEPTH`) and `ovf_o` are frozen. `in_valid_i` is ignored.
  - Handshake fires when `out_valid_o` && `out_ready_i`. On that edge, `acc`, `cnt` and `ovf` clear to 0 and the FSM returns to ACC.
  - `in_ready_o` depends on state only. It has no combinational path from `out_ready_i`.
- **Overflow**
  - Detected when an addition carries out of bit ACC_W-1.
  - The result wraps modulo 2^ACC_W and `ovf_o` is set.
  - `ovf_o` stays set until a handshake, `clr_i`, or reset.
- **clr_i**
  - When high on an edge, the block clears `acc`, `cnt` and `ovf` and enters ACC.
  - This applies in any state: a held total is discarded and a concurrently offered input is dropped.
  - Priority is `rst_i` > `clr_i` > handshake/accept.
- **Reset**
  - Asserting `rst_i` forces ACC, `acc_o`=0, `cnt_o`=0, `ovf_o`=0, `out_valid_o`=0, `in_ready_o`=1, immediately and independent of the clock.
  - Reset mid-block discards the partial sum.

## Timing
- All outputs are registered, except `in_ready_o` and `out_valid_o`, which are decoded from the state register.
- Latency: `out_valid_o` rises in the cycle after the DEPTH-th accepted result. `acc_o` holds the final total in that same cycle.
- In ACC, `acc_o`/`cnt_o` show the running values, updated one cycle after each accept.
- Throughput: at most DEPTH results per DEPTH+1 cycles. The minimum HOLD time is one cycle, when `out_ready_i`=1.
- Back-to-back blocks: the first input of the next block can be accepted in the cycle after the handshake.

## Configuration
- `ACC_SAT_EN` defined:
  - On overflow, `acc` clamps to 2^ACC_W-1 and `ovf_o` is set.
  - Later additions in the same block leave `acc` at all-ones.
- `ACC_SAT_EN` undefined: wrap-around as described in Operation. `ovf_o` behaviour is identical in both builds.

## Test plan
- **Reset mid-block:** accept 10 and 20, then pulse `rst_i` between edges → `acc_o`=0, `cnt_o`=0, `ovf_o`=0, `out_valid_o`=0 immediately; `in_ready_o`=1 after release.
- **Basic block:** n=8, DEPTH=4, ACC_W=12. Inputs 10, 20, 30, 40 back-to-back, `over_i`=0, `out_ready_i`=0 for 3 cycles:
  - `out_valid_o`=1 in the cycle after the 4th accept, with `acc_o`=100 and `cnt_o`=4.
  - While held, `in_ready_o`=0 and an offered input is ignored.
  - After the handshake: `acc_o`=0 and `cnt_o`=0.
- **Carry bit used:** four inputs of `sum_i`=0xFF with `over_i`=1 (511 each) → `acc_o`=2044 (0x7FC) and `ovf_o`=0.
- **Overflow:** ACC_W=10, four inputs of 511:
  - Without `ACC_SAT_EN`: `acc_o`=1020 and `ovf_o`=1.
  - With `ACC_SAT_EN`: `acc_o`=1023 and `ovf_o`=1.
  - In both builds, `ovf_o`=0 after the handshake.
- **Clear collision:** after 2 accepts (5, 6), drive `clr_i`=1 with `in_valid_i`=1, `sum_i`=7 → `acc_o`=0 and `cnt_o`=0 (the 7 is dropped). The next four inputs of 1 give `acc_o`=4.
- **Bubbles and clear in HOLD:**
  - Inputs 1, 2, 3, 4 with idle cycles between them → `cnt_o` advances only on accepts and the total is 10.
  - `clr_i` during HOLD → `out_valid_o` drops the next cycle with no handshake.
